// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) owning the
// architectural HI/LO registers. One operation takes 33 busy cycles followed by a one-cycle
// done pulse, at whose leading edge HI/LO are written.
//
// Optional feature: define MDU_MTHILO_EN to enable MTHI/MTLO writes through hi_we/lo_we/wd.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        start request (sampled only when idle), 00=MULT 01=MULTU 10=DIV 11=DIVU
//   src_a, src_b     multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we, wd MTHI/MTLO write enables and data
//   busy, done       operation in progress, one-cycle completion pulse
//   div_by_zero      qualified by done: divisor was zero
//   hi, lo           HI/LO registers
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;        // product/quotient must be negated
    logic               a_neg_q, a_neg_d;    // remainder must be negated
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   a_q, a_d;            // |src_a|
    logic [WIDTH-1:0]   b_q, b_d;            // |src_b|
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_out_q, dbz_out_d;

    // Start-time operand conditioning
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_rem;
    logic [2*WIDTH-1:0] div_next;

    // Fix-up results
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

`ifndef MDU_MTHILO_EN
    logic unused_mthilo;
    assign unused_mthilo = ^{hi_we, lo_we, wd};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (cnt_q == CntLast) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & src_a[WIDTH-1];
        b_neg     = signed_op & src_b[WIDTH-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;

        // Shift-add: accumulator holds {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

        // Restoring division: accumulator holds {remainder, dividend/quotient bits}.
        // When div_ge the true difference is below b_q, so a WIDTH-bit subtract suffices.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_trial >= {1'b0, b_q};
        div_diff  = div_trial[WIDTH-1:0] - b_q;
        div_rem   = div_ge ? div_diff : div_trial[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

        prod = neg_q ? -acc_q : acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        a_neg_d   = a_neg_q;
        dbz_d     = dbz_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    a_neg_d  = a_neg;
                    dbz_d    = op[1] & (src_b == '0);
                    a_d      = a_mag;
                    b_d      = b_mag;
                    acc_d    = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                end
`ifdef MDU_MTHILO_EN
                else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
`endif
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = is_div_q ? div_next : mul_next;
            end
            StFix: begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dbz_q) begin
                    // Negating the magnitude recovers the raw dividend, including 0x80000000
                    hi_d      = a_neg_q ? -a_q : a_q;
                    lo_d      = '1;
                    dbz_out_d = 1'b1;
                end else begin
                    lo_d = neg_q ? -quo : quo;
                    hi_d = a_neg_q ? -rem : rem;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            a_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            a_neg_q   <= a_neg_d;
            dbz_q     <= dbz_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors  = 0;
    int nchecks = 0;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wd          (wd),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns just after the sampling edge E0.
    task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h0BAD_F00D;
    endtask

    // Count edges until done is seen (bounded), and busy cycles on the way.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    int lat;
    int bcnt;
    int ndone;
    int nbusy;
    logic [31:0] exp_hi;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = '0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst_n = 1'b1;
        tick();

        // MTHI while idle
`ifdef MDU_MTHILO_EN
        exp_hi = 32'h0000_1234;
`else
        exp_hi = 32'h0;
`endif
        hi_we = 1'b1;
        wd    = 32'h0000_1234;
        tick();
        hi_we = 1'b0;
        chk("mthi_idle", hi, exp_hi);

        // MULTU max x max, with latency and busy length
        do_start(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("multu_lat", 32'(lat), 32'd33);
        chk("multu_busy_cycles", 32'(bcnt), 32'd33);
        chk("multu_busy_at_done", 32'(busy), 32'd0);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        chk("multu_dbz", 32'(div_by_zero), 32'd0);
        tick();
        chk("multu_done_1cyc", 32'(done), 32'd0);

        // MULT -3 x 7
        do_start(OpMult, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(lat, bcnt);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        // DIV -7 / 2, back to back on the done-ending edge
        do_start(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(lat, bcnt);
        chk("div_lat", 32'(lat), 32'd33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 100 / 0
        do_start(OpDivu, 32'd100, 32'd0);
        wait_done(lat, bcnt);
        chk("dbz_lat", 32'(lat), 32'd33);
        chk("dbz_hi", hi, 32'h0000_0064);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_flag", 32'(div_by_zero), 32'd1);
        tick();
        chk("dbz_flag_clear", 32'(div_by_zero), 32'd0);

        // DIV overflow
        do_start(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);
        chk("ovf_dbz", 32'(div_by_zero), 32'd0);

        // DIVU 10/3 with an ignored start at cycle 10
        do_start(OpDivu, 32'd10, 32'd3);
        repeat (9) tick();
        op    = OpMultu;
        src_a = 32'd2;
        src_b = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_lat", 32'(lat), 32'd23);
        chk("ign_hi", hi, 32'h1);
        chk("ign_lo", lo, 32'h3);
        do_start(OpMultu, 32'd2, 32'd2);
        wait_done(lat, bcnt);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_hi", hi, 32'h0);
        chk("b2b_lo", lo, 32'h4);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("no_queued_op", 32'(ndone), 32'd0);

        // MTLO during CALC is dropped
        do_start(OpMultu, 32'd3, 32'd3);
        lo_we = 1'b1;
        wd    = 32'h0000_5555;
        repeat (3) tick();
        lo_we = 1'b0;
        chk("mtlo_busy_lo", lo, 32'h4);
        wait_done(lat, bcnt);
        chk("mtlo_busy_res", lo, 32'h9);
        tick();

        // MTLO on the same edge as start loses
        lo_we = 1'b1;
        wd    = 32'h0000_5555;
        do_start(OpMultu, 32'd1, 32'd1);
        lo_we = 1'b0;
        chk("mtlo_start_lo", lo, 32'h9);
        wait_done(lat, bcnt);
        chk("mtlo_start_res", lo, 32'h1);
        tick();

        // Reset mid-operation
        do_start(OpMultu, 32'd5, 32'd5);
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        chk("midrst_no_busy", 32'(nbusy), 32'd0);
        do_start(OpMultu, 32'd5, 32'd5);
        wait_done(lat, bcnt);
        chk("after_rst_lo", lo, 32'd25);
        chk("after_rst_hi", hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, nchecks);
        $finish;
    end

endmodule
